// File: rtl/dadda_mul_arbiter_pkg.sv
// Shared types and the round-robin pick helper for dadda_mul_arbiter.
package dadda_arb_pkg;

  localparam int unsigned ERR_CNT_W = 16;
  localparam int unsigned MAX_REQ   = 8;

  typedef enum logic [1:0] {IDLE, CALC, RESP} arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping modulo n (n <= MAX_REQ, ptr < n).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0]         ptr,
                                       input int unsigned        n);
    rr_pick_t    r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= n) k = k - n;
      if ((i < n) && !r.found && req[k[2:0]]) begin
        r.found = 1'b1;
        r.idx   = k[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dadda_mul_arbiter_rr_arbiter.sv
// Combinational round-robin pick over NREQ requesters starting at a pointer.
module rr_arbiter
  import dadda_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [2:0]      i_ptr,
  output logic            o_found,
  output logic [2:0]      o_idx
);

  logic [MAX_REQ-1:0] w_req;
  rr_pick_t           w_pick;

  always_comb begin
    w_req            = '0;
    w_req[NREQ-1:0]  = i_req;
    w_pick           = rr_pick(w_req, i_ptr, NREQ);
  end

  assign o_found = w_pick.found;
  assign o_idx   = w_pick.idx;

endmodule

// File: rtl/dadda_mul_arbiter.sv
// Time-shares one external combinational multiplier between NREQ valid/ready lanes.
// Optional MUL_ERR_MON_EN adds err_cnt/err_max, comparing mul_out against an exact product.
module dadda_mul_arbiter
  import dadda_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_p,
  output logic [WIDTH-1:0]      mul_in1,
  output logic [WIDTH-1:0]      mul_in2,
  input  logic [2*WIDTH-1:0]    mul_out,
  output logic                  busy
`ifdef MUL_ERR_MON_EN
  ,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [2*WIDTH-1:0]    err_max
`endif
);

  localparam int unsigned PW = 2 * WIDTH;

  arb_state_t       r_state;
  logic [2:0]       r_ptr;
  logic [2:0]       r_gnt;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_prod;
  logic [NREQ-1:0]  r_rsp_valid;
  logic             r_busy;

  logic             w_found;
  logic [2:0]       w_idx;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [NREQ-1:0]  w_gnt_oh;
  logic             w_rsp_take;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_comb begin
    req_ready = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_gnt_oh  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_idx == 3'(i)) begin
        req_ready[i] = (r_state == IDLE) && w_found;
        w_sel_a      = req_a[i*WIDTH +: WIDTH];
        w_sel_b      = req_b[i*WIDTH +: WIDTH];
      end
      if (r_gnt == 3'(i)) w_gnt_oh[i] = 1'b1;
    end
  end

  // rsp_valid is one-hot on the granted lane, so this ignores other lanes' rsp_ready.
  assign w_rsp_take = |(rsp_ready & r_rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_prod      <= '0;
      r_rsp_valid <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_gnt   <= w_idx;
            r_cnt   <= 4'(SETTLE - 1);
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (r_cnt == '0) begin
            r_prod      <= mul_out;
            r_ptr       <= (r_gnt == 3'(NREQ - 1)) ? '0 : r_gnt + 3'd1;
            r_rsp_valid <= w_gnt_oh;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (w_rsp_take) begin
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_p     = r_prod;
  assign mul_in1   = r_a;
  assign mul_in2   = r_b;
  assign busy      = r_busy;

`ifdef MUL_ERR_MON_EN
  logic [PW-1:0]        w_exact;
  logic [PW-1:0]        w_diff;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [PW-1:0]        r_err_max;

  always_comb begin
    w_exact = PW'(r_a) * PW'(r_b);
    w_diff  = (w_exact > mul_out) ? (w_exact - mul_out) : (mul_out - w_exact);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
      r_err_max <= '0;
    end else if ((r_state == CALC) && (r_cnt == '0)) begin
      if ((w_diff != '0) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
      if (w_diff > r_err_max) r_err_max <= w_diff;
    end
  end

  assign err_cnt = r_err_cnt;
  assign err_max = r_err_max;
`endif

endmodule
